// File: rtl/cmd_pkt_pkg.sv
// Shared types and constants for the command packet assembler and cmd_cfg.
// Opcode and response values must match the ground-station encoding.
package cmd_pkt_pkg;

    typedef enum logic [1:0] {
        WAIT_CMD,
        WAIT_HI,
        WAIT_LO
    } rx_state_t;

    typedef enum logic {
        TX_IDLE,
        TX_BUSY
    } tx_state_t;

    localparam logic [7:0] SET_PTCH  = 8'h02;
    localparam logic [7:0] SET_ROLL  = 8'h03;
    localparam logic [7:0] SET_YAW   = 8'h04;
    localparam logic [7:0] SET_THRST = 8'h05;
    localparam logic [7:0] SET_CAL   = 8'h06;
    localparam logic [7:0] SET_EMGL  = 8'h07;
    localparam logic [7:0] SET_MOFF  = 8'h08;

    localparam logic [7:0] POS_ACK   = 8'hA5;

endpackage

// File: rtl/cmd_pkt_assembler.sv
// Frames UART bytes into {opcode, data_hi, data_lo} commands for cmd_cfg and
// forwards cmd_cfg's single-byte responses to the UART transmitter.
module cmd_pkt_assembler
    import cmd_pkt_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2_500_000,
    parameter int CNT_W          = 22
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    output logic        cmd_rdy,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        resp_sent,
    output logic [7:0]  tx_data,
    output logic        trmt,
    input  logic        tx_done,
    output logic        frame_err
);

    rx_state_t        rx_state, rx_next;
    tx_state_t        tx_state, tx_next;

    logic [7:0]       op_shadow;
    logic [7:0]       hi_shadow;
    logic [CNT_W-1:0] timeout_cnt;

    logic             byte_accept;
    logic             timeout_hit;
    logic             load_op;
    logic             load_hi;
    logic             pkt_done;

    logic             pend_valid;
    logic [7:0]       pend_data;
    logic             tx_complete;
    logic             load_tx;
    logic [7:0]       tx_load_byte;
    logic             set_pend;
    logic             clr_pend;

    // While clr_rx_rdy is high the receiver has not yet dropped rx_rdy for the old byte.
    assign byte_accept = rx_rdy && !clr_rx_rdy;
    assign timeout_hit = (rx_state != WAIT_CMD) && !byte_accept &&
                         (timeout_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        rx_next = rx_state;
        load_op = 1'b0;
        load_hi = 1'b0;
        pkt_done = 1'b0;
        case (rx_state)
            WAIT_CMD: begin
                if (byte_accept) begin
                    load_op = 1'b1;
                    rx_next = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (byte_accept) begin
                    load_hi = 1'b1;
                    rx_next = WAIT_LO;
                end else if (timeout_hit) begin
                    rx_next = WAIT_CMD;
                end
            end
            WAIT_LO: begin
                if (byte_accept) begin
                    pkt_done = 1'b1;
                    rx_next  = WAIT_CMD;
                end else if (timeout_hit) begin
                    rx_next = WAIT_CMD;
                end
            end
            default: rx_next = WAIT_CMD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state    <= WAIT_CMD;
            op_shadow   <= '0;
            hi_shadow   <= '0;
            timeout_cnt <= '0;
            clr_rx_rdy  <= 1'b0;
            frame_err   <= 1'b0;
            cmd_rdy     <= 1'b0;
            cmd         <= '0;
            data        <= '0;
        end else begin
            rx_state   <= rx_next;
            clr_rx_rdy <= byte_accept;
            frame_err  <= timeout_hit;
            if (rx_state == WAIT_CMD || byte_accept || timeout_hit)
                timeout_cnt <= '0;
            else
                timeout_cnt <= timeout_cnt + CNT_W'(1);
            if (load_op)
                op_shadow <= rx_data;
            if (load_hi)
                hi_shadow <= rx_data;
            // A completing packet outranks a simultaneous acknowledge.
            if (pkt_done) begin
                cmd     <= op_shadow;
                data    <= {hi_shadow, rx_data};
                cmd_rdy <= 1'b1;
            end else if (clr_cmd_rdy || load_op) begin
                cmd_rdy <= 1'b0;
            end
        end
    end

    // tx_done is still high from the previous byte during the trmt cycle, so ignore it then.
    assign tx_complete = (tx_state == TX_BUSY) && !trmt && tx_done;

    always_comb begin
        tx_next      = tx_state;
        load_tx      = 1'b0;
        tx_load_byte = resp;
        set_pend     = 1'b0;
        clr_pend     = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (send_resp) begin
                    load_tx = 1'b1;
                    tx_next = TX_BUSY;
                end
            end
            TX_BUSY: begin
                if (tx_complete) begin
                    if (send_resp) begin
                        load_tx  = 1'b1;
                        clr_pend = 1'b1;
                    end else if (pend_valid) begin
                        load_tx      = 1'b1;
                        tx_load_byte = pend_data;
                        clr_pend     = 1'b1;
                    end else begin
                        tx_next = TX_IDLE;
                    end
                end else if (send_resp) begin
                    set_pend = 1'b1;
                end
            end
            default: tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state   <= TX_IDLE;
            tx_data    <= '0;
            trmt       <= 1'b0;
            resp_sent  <= 1'b0;
            pend_valid <= 1'b0;
            pend_data  <= '0;
        end else begin
            tx_state  <= tx_next;
            trmt      <= load_tx;
            resp_sent <= tx_complete;
            if (load_tx)
                tx_data <= tx_load_byte;
            if (clr_pend)
                pend_valid <= 1'b0;
            else if (set_pend)
                pend_valid <= 1'b1;
            if (set_pend)
                pend_data <= resp;
        end
    end

endmodule

// File: tb/tb_cmd_pkt_assembler.sv
// Directed bench for cmd_pkt_assembler: table of packets plus hand-written
// sequences for timeout resync, opcode preemption, set-wins and TX queuing.
module tb_cmd_pkt_assembler;
    import cmd_pkt_pkg::*;

    logic        clk;
    logic        rst;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    logic        cmd_rdy;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        send_resp;
    logic        resp_sent;
    logic [7:0]  tx_data;
    logic        trmt;
    logic        tx_done;
    logic        frame_err;

    int compared;
    int mismatched;
    int clr_cnt;
    int trmt_cnt;
    int resp_cnt;

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [7:0]  exp_cmd;
        logic [15:0] exp_data;
    } pkt_vec_t;

    pkt_vec_t vecs [4];

    cmd_pkt_assembler #(
        .TIMEOUT_CYCLES(100),
        .CNT_W(22)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_rdy(rx_rdy),
        .rx_data(rx_data),
        .clr_rx_rdy(clr_rx_rdy),
        .cmd_rdy(cmd_rdy),
        .cmd(cmd),
        .data(data),
        .clr_cmd_rdy(clr_cmd_rdy),
        .resp(resp),
        .send_resp(send_resp),
        .resp_sent(resp_sent),
        .tx_data(tx_data),
        .trmt(trmt),
        .tx_done(tx_done),
        .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (clr_rx_rdy) clr_cnt++;
        if (trmt)       trmt_cnt++;
        if (resp_sent)  resp_cnt++;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int w;
        @(negedge clk);
        rx_rdy  = 1'b1;
        rx_data = b;
        w = 0;
        @(negedge clk);
        while (!clr_rx_rdy && w < 10) begin
            @(negedge clk);
            w++;
        end
        if (!clr_rx_rdy)
            checkOutput("clr_rx_rdy_wait", 32'(clr_rx_rdy), 32'd1);
        rx_rdy = 1'b0;
    endtask

    task automatic ack_cmd();
        @(negedge clk);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_cmd_rdy"},    32'(cmd_rdy),    32'd0);
        checkOutput({tag, "_cmd"},        32'(cmd),        32'd0);
        checkOutput({tag, "_data"},       32'(data),       32'd0);
        checkOutput({tag, "_tx_data"},    32'(tx_data),    32'd0);
        checkOutput({tag, "_trmt"},       32'(trmt),       32'd0);
        checkOutput({tag, "_resp_sent"},  32'(resp_sent),  32'd0);
        checkOutput({tag, "_frame_err"},  32'(frame_err),  32'd0);
        checkOutput({tag, "_clr_rx_rdy"}, 32'(clr_rx_rdy), 32'd0);
    endtask

    // Sends one packet with 10-cycle gaps, checks 1-cycle completion latency, then acknowledges.
    task automatic applyStimulus(input pkt_vec_t v, input int idx);
        int clr_base;
        clr_base = clr_cnt;
        send_byte(v.b0);
        repeat (10) @(negedge clk);
        send_byte(v.b1);
        checkOutput($sformatf("pkt%0d_rdy_early", idx), 32'(cmd_rdy), 32'd0);
        repeat (10) @(negedge clk);
        send_byte(v.b2);
        checkOutput($sformatf("pkt%0d_cmd_rdy", idx), 32'(cmd_rdy), 32'd1);
        checkOutput($sformatf("pkt%0d_cmd", idx), 32'(cmd), 32'(v.exp_cmd));
        checkOutput($sformatf("pkt%0d_data", idx), 32'(data), 32'(v.exp_data));
        ack_cmd();
        checkOutput($sformatf("pkt%0d_ack", idx), 32'(cmd_rdy), 32'd0);
        checkOutput($sformatf("pkt%0d_cmd_held", idx), 32'(cmd), 32'(v.exp_cmd));
        repeat (2) @(negedge clk);
        checkOutput($sformatf("pkt%0d_clr_pulses", idx), 32'(clr_cnt - clr_base), 32'd3);
    endtask

    initial begin
        int k;
        int tb_trmt;
        int tb_resp;

        compared    = 0;
        mismatched  = 0;
        clr_cnt     = 0;
        trmt_cnt    = 0;
        resp_cnt    = 0;
        rst         = 1'b1;
        rx_rdy      = 1'b0;
        rx_data     = 8'h00;
        clr_cmd_rdy = 1'b0;
        resp        = 8'h00;
        send_resp   = 1'b0;
        tx_done     = 1'b0;

        vecs[0] = '{b0: 8'h02, b1: 8'h12, b2: 8'h34, exp_cmd: 8'h02, exp_data: 16'h1234};
        vecs[1] = '{b0: 8'h04, b1: 8'h00, b2: 8'h01, exp_cmd: 8'h04, exp_data: 16'h0001};
        vecs[2] = '{b0: 8'h05, b1: 8'hA5, b2: 8'h5A, exp_cmd: 8'h05, exp_data: 16'hA55A};
        vecs[3] = '{b0: 8'h07, b1: 8'hFF, b2: 8'h00, exp_cmd: 8'h07, exp_data: 16'hFF00};

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] packet table");
        for (int i = 0; i < 4; i++)
            applyStimulus(vecs[i], i);

        $display("[TB] inter-byte timeout");
        send_byte(SET_THRST);
        send_byte(8'h00);
        k = 0;
        while (!frame_err && k < 300) begin
            @(negedge clk);
            k++;
        end
        checkOutput("ferr_seen", 32'(frame_err), 32'd1);
        checkOutput("ferr_latency", 32'(k), 32'd100);
        checkOutput("ferr_cmd_kept", 32'(cmd), 32'h07);
        checkOutput("ferr_data_kept", 32'(data), 32'hFF00);
        checkOutput("ferr_rdy_kept", 32'(cmd_rdy), 32'd0);
        @(negedge clk);
        checkOutput("ferr_width", 32'(frame_err), 32'd0);
        send_byte(SET_ROLL);
        send_byte(8'hAB);
        send_byte(8'hCD);
        checkOutput("resync_rdy", 32'(cmd_rdy), 32'd1);
        checkOutput("resync_cmd", 32'(cmd), 32'h03);
        checkOutput("resync_data", 32'(data), 32'hABCD);
        ack_cmd();

        $display("[TB] opcode preempts unacknowledged packet");
        send_byte(SET_YAW);
        send_byte(8'h00);
        send_byte(8'h01);
        checkOutput("pre_rdy", 32'(cmd_rdy), 32'd1);
        checkOutput("pre_data", 32'(data), 32'h0001);
        send_byte(SET_CAL);
        checkOutput("pre_drop", 32'(cmd_rdy), 32'd0);
        checkOutput("pre_cmd_held", 32'(cmd), 32'h04);
        send_byte(8'hFF);
        send_byte(8'hFF);
        checkOutput("pre2_rdy", 32'(cmd_rdy), 32'd1);
        checkOutput("pre2_cmd", 32'(cmd), 32'h06);
        checkOutput("pre2_data", 32'(data), 32'hFFFF);

        $display("[TB] completion beats simultaneous ack");
        send_byte(SET_MOFF);
        send_byte(8'h00);
        @(negedge clk);
        rx_rdy      = 1'b1;
        rx_data     = 8'h00;
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        checkOutput("setwins_clr_rx", 32'(clr_rx_rdy), 32'd1);
        rx_rdy = 1'b0;
        checkOutput("setwins_rdy", 32'(cmd_rdy), 32'd1);
        repeat (3) @(negedge clk);
        checkOutput("setwins_rdy_hold", 32'(cmd_rdy), 32'd1);
        checkOutput("setwins_cmd", 32'(cmd), 32'h08);
        checkOutput("setwins_data", 32'(data), 32'h0000);

        $display("[TB] single response");
        tb_trmt = trmt_cnt;
        tb_resp = resp_cnt;
        @(negedge clk);
        resp      = POS_ACK;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        checkOutput("tx1_trmt", 32'(trmt), 32'd1);
        checkOutput("tx1_data", 32'(tx_data), 32'hA5);
        repeat (20) @(negedge clk);
        checkOutput("tx1_no_early_sent", 32'(resp_cnt - tb_resp), 32'd0);
        tx_done = 1'b1;
        @(negedge clk);
        checkOutput("tx1_resp_sent", 32'(resp_sent), 32'd1);
        @(negedge clk);
        checkOutput("tx1_resp_width", 32'(resp_sent), 32'd0);
        repeat (5) @(negedge clk);
        checkOutput("tx1_trmt_count", 32'(trmt_cnt - tb_trmt), 32'd1);
        checkOutput("tx1_sent_count", 32'(resp_cnt - tb_resp), 32'd1);

        $display("[TB] queued responses, last wins");
        tb_trmt = trmt_cnt;
        tb_resp = resp_cnt;
        @(negedge clk);
        resp      = POS_ACK;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        tx_done   = 1'b0;
        checkOutput("txq_trmt1", 32'(trmt), 32'd1);
        @(negedge clk);
        resp      = 8'h11;
        send_resp = 1'b1;
        @(negedge clk);
        resp      = 8'h22;
        @(negedge clk);
        send_resp = 1'b0;
        repeat (5) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        checkOutput("txq_resp1", 32'(resp_sent), 32'd1);
        checkOutput("txq_trmt2", 32'(trmt), 32'd1);
        checkOutput("txq_data2", 32'(tx_data), 32'h22);
        tx_done = 1'b0;
        repeat (10) @(negedge clk);
        tx_done = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("txq_trmt_count", 32'(trmt_cnt - tb_trmt), 32'd2);
        checkOutput("txq_sent_count", 32'(resp_cnt - tb_resp), 32'd2);

        $display("[TB] reset during transfer");
        tb_trmt = trmt_cnt;
        tb_resp = resp_cnt;
        @(negedge clk);
        resp      = 8'h44;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        tx_done   = 1'b0;
        @(negedge clk);
        resp      = 8'h55;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        rst       = 1'b1;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst     = 1'b0;
        tx_done = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("midrst_trmt_count", 32'(trmt_cnt - tb_trmt), 32'd1);
        checkOutput("midrst_sent_count", 32'(resp_cnt - tb_resp), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
